// File: rtl/score_seg_scanner.sv
// ---------------------------------------------------------------------------
// score_seg_scanner
//   Multiplexed 7-segment scoreboard driver. Two binary scores are converted
//   to decimal by a sequential double-dabble engine once per display frame and
//   shown on NUM_DIGITS time-multiplexed digits. The lower half of the digits
//   shows score2, the upper half shows score1. Values above the half's decimal
//   range saturate to all nines.
//
//   Optional feature macro: BLINK_EN
//     defined   : 6-bit frame counter; while blink=1 and the blink phase is 1
//                 all anodes are forced off (phase toggles every 32 frames).
//     undefined : blink is ignored and the display is never forced off.
//
//   Parameters
//     NUM_DIGITS  : total digits, even, 2..8
//     REFRESH_DIV : cycles each digit stays lit (>= SCORE_W+4)
//     SCORE_W     : width of each score input, 1..16
//     ACTIVE_LOW  : 1 = seg/an active-low, 0 = active-high
//
//   Ports
//     clk_100MHz : system clock
//     reset      : synchronous, active-high
//     score1     : player-1 score (upper half of the display)
//     score2     : player-2 score (lower half of the display)
//     blank_lz   : 1 = blank leading zeros within each half
//     blink      : game-over blink request (BLINK_EN builds only)
//     seg        : registered segments, seg[0]=a .. seg[6]=g
//     an         : registered digit enables, an[0] = rightmost digit
// ---------------------------------------------------------------------------
module score_seg_scanner #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 250000,
  parameter int unsigned SCORE_W     = 4,
  parameter int unsigned ACTIVE_LOW  = 1
) (
  input  logic                  clk_100MHz,
  input  logic                  reset,
  input  logic [SCORE_W-1:0]    score1,
  input  logic [SCORE_W-1:0]    score2,
  input  logic                  blank_lz,
  input  logic                  blink,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int unsigned HALF  = NUM_DIGITS / 2;
  localparam int unsigned BCD_W = 4 * HALF;
  localparam int unsigned SR_W  = BCD_W + SCORE_W;
  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BIT_W = $clog2(SCORE_W + 1);

  // Largest value a half can show: 9, 99, 999 or 9999.
  localparam int unsigned MAX_VAL = (HALF == 1) ? 9 :
                                    (HALF == 2) ? 99 :
                                    (HALF == 3) ? 999 : 9999;

  localparam logic [6:0]            SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                : {NUM_DIGITS{1'b0}};

  typedef enum logic [1:0] {
    CV_IDLE  = 2'd0,
    CV_SHIFT = 2'd1,
    CV_LOAD  = 2'd2
  } cv_state_t;

  // Active-high segment pattern (g..a) for one decimal digit.
  function automatic logic [6:0] enc7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Saturate so that the converted value always fits in HALF BCD digits.
  function automatic logic [SCORE_W-1:0] clamp_score(input logic [SCORE_W-1:0] v);
    logic [SCORE_W-1:0] r;
    r = v;
    if (32'(v) > MAX_VAL) r = SCORE_W'(MAX_VAL);
    return r;
  endfunction

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
  function automatic logic [SR_W-1:0] dd_step(input logic [SR_W-1:0] v);
    logic [SR_W-1:0] t;
    t = v;
    for (int unsigned d = 0; d < HALF; d++) begin
      if (t[SCORE_W + 4*d +: 4] >= 4'd5)
        t[SCORE_W + 4*d +: 4] = t[SCORE_W + 4*d +: 4] + 4'd3;
    end
    return {t[SR_W-2:0], 1'b0};
  endfunction

  // -------------------------------------------------------------------------
  // Refresh counter and digit index
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             r_lit;
  logic             w_wrap;
  logic             w_frame_start;

  assign w_wrap = (r_cnt == CNT_W'(REFRESH_DIV - 1));
  // The first wrap after reset lights index 0, so it also starts a frame.
  assign w_frame_start = w_wrap && (!r_lit || (r_idx == IDX_W'(NUM_DIGITS - 1)));

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_lit <= 1'b0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_lit <= 1'b1;
      if (w_frame_start) r_idx <= '0;
      else               r_idx <= r_idx + IDX_W'(1);
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Converter FSM
  // -------------------------------------------------------------------------
  cv_state_t        r_state;
  cv_state_t        w_state_nxt;
  logic             w_shift;
  logic             w_load;
  logic [BIT_W-1:0] r_bit;

  always_ff @(posedge clk_100MHz) begin
    if (reset) r_state <= CV_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift     = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      CV_IDLE: w_state_nxt = CV_IDLE;
      CV_SHIFT: begin
        w_shift = 1'b1;
        if (r_bit == BIT_W'(SCORE_W - 1)) w_state_nxt = CV_LOAD;
      end
      CV_LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = CV_IDLE;
      end
      default: w_state_nxt = CV_IDLE;
    endcase
    // A frame start always (re)launches a conversion from the new snapshot.
    if (w_frame_start) w_state_nxt = CV_SHIFT;
  end

  // -------------------------------------------------------------------------
  // Conversion datapath and display registers
  // -------------------------------------------------------------------------
  logic [SR_W-1:0]  r_sr1;
  logic [SR_W-1:0]  r_sr2;
  logic [BCD_W-1:0] r_disp1;
  logic [BCD_W-1:0] r_disp2;

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      r_sr1   <= '0;
      r_sr2   <= '0;
      r_bit   <= '0;
      r_disp1 <= '0;
      r_disp2 <= '0;
    end else begin
      if (w_frame_start) begin
        r_sr1 <= {BCD_W'(0), clamp_score(score1)};
        r_sr2 <= {BCD_W'(0), clamp_score(score2)};
        r_bit <= '0;
      end else if (w_shift) begin
        r_sr1 <= dd_step(r_sr1);
        r_sr2 <= dd_step(r_sr2);
        r_bit <= r_bit + BIT_W'(1);
      end
      // Both halves update together so no frame shows mixed old/new digits.
      if (w_load) begin
        r_disp1 <= r_sr1[SR_W-1 -: BCD_W];
        r_disp2 <= r_sr2[SR_W-1 -: BCD_W];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Optional blink phase
  // -------------------------------------------------------------------------
`ifdef BLINK_EN
  logic [5:0] r_frame_cnt;
  logic       w_blank_all;

  always_ff @(posedge clk_100MHz) begin
    if (reset)              r_frame_cnt <= '0;
    else if (w_frame_start) r_frame_cnt <= r_frame_cnt + 6'd1;
  end

  // MSB of the frame counter toggles every 32 frames: it is the blink phase.
  assign w_blank_all = blink && r_frame_cnt[5];
`else
  logic w_blink_unused;
  logic w_blank_all;

  assign w_blink_unused = blink;
  assign w_blank_all    = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Digit selection, leading-zero blanking and encoding
  // -------------------------------------------------------------------------
  logic [BCD_W-1:0]      w_half;
  logic [IDX_W-1:0]      w_pos;
  logic [3:0]            w_digit;
  logic                  w_upper_zero;
  logic                  w_blank;
  logic [6:0]            w_seg_ah;
  logic [NUM_DIGITS-1:0] w_an_ah;

  always_comb begin
    w_half       = r_disp2;
    w_pos        = r_idx;
    w_upper_zero = 1'b1;
    w_digit      = 4'd0;
    w_blank      = 1'b0;
    w_seg_ah     = 7'h00;
    w_an_ah      = '0;

    if (r_idx >= IDX_W'(HALF)) begin
      w_half = r_disp1;
      w_pos  = r_idx - IDX_W'(HALF);
    end
    w_digit = w_half[32'(w_pos) * 4 +: 4];

    // Blank only if this digit and all more significant digits in the half are 0.
    for (int unsigned d = 0; d < HALF; d++) begin
      if ((d >= 32'(w_pos)) && (w_half[4*d +: 4] != 4'd0)) w_upper_zero = 1'b0;
    end
    w_blank = blank_lz && (w_pos != '0) && w_upper_zero;

    if (r_lit) begin
      w_an_ah  = NUM_DIGITS'(1) << r_idx;
      w_seg_ah = w_blank ? 7'h00 : enc7(w_digit);
    end
    if (w_blank_all) w_an_ah = '0;
  end

  // Registered outputs with polarity applied.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      seg <= SEG_OFF;
      an  <= AN_OFF;
    end else begin
      seg <= (ACTIVE_LOW != 0) ? ~w_seg_ah : w_seg_ah;
      an  <= (ACTIVE_LOW != 0) ? ~w_an_ah  : w_an_ah;
    end
  end

endmodule

// File: doc/score_seg_scanner.md
Name: score_seg_scanner

Overview:
Parametrised multiplexed 7-segment scoreboard driver for the Basys 3 Pong design. It generalises the fixed 4-digit, hex-only score mux to any even digit count, any score width and either display polarity. Scores are converted to decimal by a sequential double-dabble engine, with optional leading-zero blanking and game-over blink. It sits beside the VGA path and consumes score1/score2 from the game logic.

Parameters:
NUM_DIGITS, 4, total digits; even, 2..8; lower half shows score2, upper half shows score1.
REFRESH_DIV, 250000, clock cycles each digit stays lit; must be >= SCORE_W+4.
SCORE_W, 4, bit width of each score input, 1..16.
ACTIVE_LOW, 1, 1 = seg/an driven active-low (Basys 3); 0 = active-high.

Ports:
clk_100MHz  input  1  system clock
reset  input  1  synchronous, active-high
score1  input  SCORE_W  player-1 score, unsigned binary
score2  input  SCORE_W  player-2 score, unsigned binary
blank_lz  input  1  1 = blank leading zeros in each half
blink  input  1  game-over blink request (used only with BLINK_EN)
seg  output  7  segments; seg[0]=a ... seg[6]=g
an  output  NUM_DIGITS  digit enables; an[0] = rightmost digit

Behaviour:
- Reset, synchronous, active-high, one clock: refresh counter = 0; digit index = 0; `lit` flag = 0; display BCD registers = 0; converter idle; blink phase = 0. seg = all segments off and an = all digits off (polarity per ACTIVE_LOW). A reset mid-conversion or mid-frame aborts everything and restarts from this state.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - At the wrap edge, `lit` is set to 1 and the digit index advances. The first wrap after reset lights index 0. After that, NUM_DIGITS-1 wraps to 0.
  - Each digit is lit for exactly REFRESH_DIV cycles.
- Frame snapshot:
  - On the wrap edge that moves the index to 0, score1 and score2 are latched and the converter starts.
  - Score changes at any other time are ignored until the next frame start.
- Converter:
  - FSM IDLE -> SHIFT (SCORE_W cycles, add-3 then shift, both scores in parallel) -> LOAD (1 cycle) -> IDLE.
  - In LOAD the display BCD registers update atomically, so there is no tearing between digits.
  - Each half is NUM_DIGITS/2 digits. A value above 10^(NUM_DIGITS/2)-1 saturates to all nines.
- Digit mapping:
  - Index i < NUM_DIGITS/2 shows decimal digit i of score2.
  - Index i >= NUM_DIGITS/2 shows decimal digit (i - NUM_DIGITS/2) of score1.
- Leading-zero blanking: when blank_lz = 1, a digit is blanked if it and every higher digit in its half are 0. The least-significant digit of each half is never blanked.
- Blanked digit: its an bit stays active and seg = all off.
- Output timing: seg and an are registered. Each cycle they are computed from the previous cycle's index, lit flag and display registers, so they lag the index by 1 cycle. At most one an bit is active at a time.
- Encoding (active-high, g..a):
  - 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110
  - 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111
  - ACTIVE_LOW inverts both seg and an.
- Latency: a score change is displayed no later than one full frame plus SCORE_W+3 cycles.

Optional Feature:
Macro BLINK_EN.
- Defined: a 6-bit frame counter increments at each frame start, and the blink phase toggles every 32 frames. While blink = 1 and the phase = 1, an = all off. When blink deasserts, the display returns on the next cycle; the phase counter keeps running.
- Undefined: the blink input is ignored, no frame counter is synthesised, and the display is never forced off.

Test Plan:
Common setup for all scenarios: NUM_DIGITS=4, REFRESH_DIV=8, SCORE_W=4, ACTIVE_LOW=1.
1. Reset, then score1=12 and score2=7 held, blank_lz=0. Required across the second frame:
   - an=1110, seg=7'h78
   - an=1101, seg=7'h40
   - an=1011, seg=7'h24
   - an=0111, seg=7'h79
   - each held 8 cycles.
2. Same scores with blank_lz=1, score2=7. The an=1101 slot shows seg=7'h7F (blank); the ones digit still shows 7'h78.
3. Change score2 from 7 to 3 mid-frame at digit 2. Digit 0 keeps 7'h78 until the next frame; after that frame's conversion, digit 0 shows 7'h30.
4. SCORE_W=7, score1=120. Upper half saturates to "99": seg=7'h10 in both upper slots.
5. Assert reset during SHIFT. Next cycle: seg=7'h7F and an=1111; first digit lit at cycle 8 after reset release; display registers read 0 until the new conversion loads.
6. BLINK_EN defined, blink=1. After 32 frames an=1111 for 32 frames, then scanning resumes. With the macro undefined, scanning never stops.
